// File: rtl/stream_intf_pkg.sv
// Shared stream-interface constants and types for the Mage in/out stream units.
package stream_intf_pkg;

  localparam int unsigned N_PEA_DOUT_PER_OUT_STREAM     = 4;
  localparam int unsigned N_DMA_CH_PER_OUT_STREAM       = 4;
  localparam int unsigned LOG_N_PEA_DOUT_PER_OUT_STREAM = $clog2(N_PEA_DOUT_PER_OUT_STREAM);
  localparam int unsigned OUT_STREAM_DATA_W             = 32;
  localparam int unsigned OUT_STREAM_FIFO_DEPTH         = 4;
  localparam int unsigned OUT_STREAM_CNT_W              = 16;

  // Legacy state encodings, also used as the enum values below
  localparam logic [1:0] OS_ST_IDLE  = 2'd0;
  localparam logic [1:0] OS_ST_RUN   = 2'd1;
  localparam logic [1:0] OS_ST_DRAIN = 2'd2;
  localparam logic [1:0] OS_ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    OS_IDLE  = OS_ST_IDLE,
    OS_RUN   = OS_ST_RUN,
    OS_DRAIN = OS_ST_DRAIN,
    OS_DONE  = OS_ST_DONE
  } out_stream_state_e;

endpackage

// File: rtl/mage_stream_fifo.sv
// Small synchronous FIFO; head is the oldest entry, full/empty decode from registered pointers.
module mage_stream_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;

  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Next-state for storage and pointers; push into a full FIFO is refused
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // Storage and pointer registers; reset discards all buffered data
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) mem_q[k] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mage_out_stream_unit.sv
// Mage output-stream unit: crossbar from PEA outputs to per-channel FIFOs feeding DMA channels.
// Optional stall counter on perf_stall_o when MAGE_OUT_STREAM_PERF_EN is defined.
module mage_out_stream_unit
  import stream_intf_pkg::*;
#(
  parameter int unsigned N_PEA_DOUT = N_PEA_DOUT_PER_OUT_STREAM,
  parameter int unsigned N_DMA_CH   = N_DMA_CH_PER_OUT_STREAM,
  parameter int unsigned DATA_W     = OUT_STREAM_DATA_W,
  parameter int unsigned FIFO_DEPTH = OUT_STREAM_FIFO_DEPTH,
  parameter int unsigned CNT_W      = OUT_STREAM_CNT_W,
  localparam int unsigned SEL_W     = (N_PEA_DOUT > 1) ? $clog2(N_PEA_DOUT) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic [N_DMA_CH*SEL_W-1:0]    cfg_sel_i,
  input  logic [N_DMA_CH-1:0]          cfg_ch_en_i,
  input  logic [CNT_W-1:0]             cfg_len_i,
  input  logic [N_PEA_DOUT*DATA_W-1:0] pea_dout_i,
  input  logic [N_PEA_DOUT-1:0]        pea_dout_valid_i,
  output logic [N_PEA_DOUT-1:0]        pea_dout_ready_o,
  output logic [N_DMA_CH*DATA_W-1:0]   dma_data_o,
  output logic [N_DMA_CH-1:0]          dma_valid_o,
  input  logic [N_DMA_CH-1:0]          dma_ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [31:0]                  perf_stall_o
);

  out_stream_state_e          state_q, state_d;
  logic [N_DMA_CH*SEL_W-1:0]  sel_q, sel_d;
  logic [N_DMA_CH-1:0]        ch_en_q, ch_en_d;
  logic [CNT_W-1:0]           len_q, len_d;
  logic [CNT_W-1:0]           cnt_q [N_DMA_CH];
  logic [CNT_W-1:0]           cnt_d [N_DMA_CH];

  logic [N_DMA_CH-1:0]        acc, push, pop, sel_ok;
  logic [N_DMA_CH-1:0]        fifo_full, fifo_empty;
  logic [DATA_W-1:0]          fifo_head [N_DMA_CH];
  logic [DATA_W-1:0]          push_data [N_DMA_CH];
  logic [N_PEA_DOUT-1:0]      pea_any, pea_all, pea_rdy;
  logic                       all_done;

  assign busy_o           = (state_q != OS_IDLE);
  assign done_o           = (state_q == OS_DONE);
  assign pea_dout_ready_o = pea_rdy;
  assign pop              = ~fifo_empty & dma_ready_i;

  // Channel accept, fork-join PEA ready (all consumers must accept) and push routing
  always_comb begin
    acc     = '0;
    sel_ok  = '0;
    pea_any = '0;
    pea_all = '1;
    push    = '0;
    for (int i = 0; i < int'(N_DMA_CH); i++) begin
      push_data[i] = '0;
      acc[i] = (state_q == OS_RUN) && ch_en_q[i] && !fifo_full[i] && (cnt_q[i] < len_q);
      for (int j = 0; j < int'(N_PEA_DOUT); j++) begin
        if (sel_q[i*SEL_W +: SEL_W] == SEL_W'(j)) begin
          sel_ok[i] = 1'b1;
          if (ch_en_q[i]) begin
            pea_any[j] = 1'b1;
            if (!acc[i]) pea_all[j] = 1'b0;
          end
        end
      end
    end
    pea_rdy = (state_q == OS_RUN) ? (pea_any & pea_all) : '0;
    for (int i = 0; i < int'(N_DMA_CH); i++) begin
      for (int j = 0; j < int'(N_PEA_DOUT); j++) begin
        if (ch_en_q[i] && (sel_q[i*SEL_W +: SEL_W] == SEL_W'(j))) begin
          push[i]      = pea_dout_valid_i[j] && pea_rdy[j];
          push_data[i] = pea_dout_i[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Control FSM, config latch and per-channel word counters
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ch_en_d  = ch_en_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    all_done = 1'b1;
    for (int i = 0; i < int'(N_DMA_CH); i++) begin
      if (ch_en_q[i] && (cnt_q[i] != len_q)) all_done = 1'b0;
      if (push[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
    case (state_q)
      OS_IDLE: begin
        if (start_i) begin
          sel_d   = cfg_sel_i;
          ch_en_d = cfg_ch_en_i;
          len_d   = cfg_len_i;
          for (int i = 0; i < int'(N_DMA_CH); i++) cnt_d[i] = '0;
          state_d = ((cfg_len_i == '0) || (cfg_ch_en_i == '0)) ? OS_DRAIN : OS_RUN;
        end
      end
      OS_RUN:   if (all_done) state_d = OS_DRAIN;
      OS_DRAIN: if (&fifo_empty) state_d = OS_DONE;
      OS_DONE:  state_d = OS_IDLE;
      default:  state_d = OS_IDLE;
    endcase
  end

  // State, config and counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= OS_IDLE;
      sel_q   <= '0;
      ch_en_q <= '0;
      len_q   <= '0;
      for (int i = 0; i < int'(N_DMA_CH); i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ch_en_q <= ch_en_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < int'(N_DMA_CH); g++) begin : g_ch
    mage_stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push[g]),
      .data_i  (push_data[g]),
      .pop_i   (pop[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g]),
      .head_o  (fifo_head[g])
    );
    assign dma_data_o[g*DATA_W +: DATA_W] = fifo_head[g];
    assign dma_valid_o[g]                 = ~fifo_empty[g];
  end

`ifdef MAGE_OUT_STREAM_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        stall;

  // Saturating DMA backpressure counter, cleared when a transfer starts
  always_comb begin
    stall  = ((state_q == OS_RUN) || (state_q == OS_DRAIN)) &&
             (|(ch_en_q & ~fifo_empty & ~dma_ready_i));
    perf_d = perf_q;
    if ((state_q == OS_IDLE) && start_i) perf_d = '0;
    else if (stall && (perf_q != '1))    perf_d = perf_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif

  // An enabled channel selecting a non-existent PEA output would hang the transfer
  a_sel_in_range: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q == OS_RUN) |-> ((ch_en_q & ~sel_ok) == '0));

endmodule

// File: tb/tb_mage_out_stream_unit.sv
// Directed bench for mage_out_stream_unit with per-channel scoreboard queues.
module tb_mage_out_stream_unit;

  localparam int unsigned NP = 4;
  localparam int unsigned NC = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = 2;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              start_i = 1'b0;
  logic [NC*SW-1:0]  cfg_sel_i = '0;
  logic [NC-1:0]     cfg_ch_en_i = '0;
  logic [CW-1:0]     cfg_len_i = '0;
  logic [NP*DW-1:0]  pea_dout_i;
  logic [NP-1:0]     pea_dout_valid_i;
  logic [NP-1:0]     pea_dout_ready_o;
  logic [NC*DW-1:0]  dma_data_o;
  logic [NC-1:0]     dma_valid_o;
  logic [NC-1:0]     dma_ready_i = '1;
  logic              busy_o, done_o;
  logic [31:0]       perf_stall_o;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]        test_id = 8'd0;
  int unsigned       src_idx [NP];
  logic [NP-1:0]     src_on = '0;
  logic [NP-1:0]     src_hs;
  logic [31:0]       exp_q [NC][$];
  logic [NC-1:0]     seen_vld = '0;
  logic [NP-1:0]     seen_rdy = '0;
  logic [31:0]       perf_val;

  mage_out_stream_unit dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .start_i          (start_i),
    .cfg_sel_i        (cfg_sel_i),
    .cfg_ch_en_i      (cfg_ch_en_i),
    .cfg_len_i        (cfg_len_i),
    .pea_dout_i       (pea_dout_i),
    .pea_dout_valid_i (pea_dout_valid_i),
    .pea_dout_ready_o (pea_dout_ready_o),
    .dma_data_o       (dma_data_o),
    .dma_valid_o      (dma_valid_o),
    .dma_ready_i      (dma_ready_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .perf_stall_o     (perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mkword(input int j, input int unsigned k);
    return {8'(j + 1), test_id, 16'(k)};
  endfunction

  // PEA sources: word k of output j is {j+1, test_id, k}
  always_comb begin
    for (int j = 0; j < int'(NP); j++)
      pea_dout_i[j*DW +: DW] = {8'(j + 1), test_id, 16'(src_idx[j])};
  end
  assign pea_dout_valid_i = src_on;

  // Advance a source after each accepted PEA handshake
  initial begin
    for (int j = 0; j < int'(NP); j++) src_idx[j] = 0;
    forever begin
      @(negedge clk_i);
      src_hs = pea_dout_valid_i & pea_dout_ready_o;
      @(posedge clk_i);
      #1;
      for (int j = 0; j < int'(NP); j++) if (src_hs[j]) src_idx[j] = src_idx[j] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // DMA-side monitor: every popped word must match the scoreboard head
  always @(negedge clk_i) begin
    seen_vld = seen_vld | dma_valid_o;
    seen_rdy = seen_rdy | pea_dout_ready_o;
    for (int i = 0; i < int'(NC); i++) begin
      if (dma_valid_o[i] && dma_ready_i[i]) begin
        logic [31:0] e;
        e = (exp_q[i].size() != 0) ? exp_q[i].pop_front() : 32'hFFFF_FFFF;
        chk($sformatf("ch%0d_data", i), dma_data_o[i*DW +: DW], e);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_dma_valid"}, 32'(dma_valid_o), 32'd0);
    chk({tag, "_pea_ready"}, 32'(pea_dout_ready_o), 32'd0);
    chk({tag, "_perf"}, perf_stall_o, 32'd0);
    for (int i = 0; i < int'(NC); i++)
      chk($sformatf("%s_data%0d", tag, i), dma_data_o[i*DW +: DW], 32'd0);
  endtask

  // Load scoreboard, pulse start, then scramble cfg inputs to prove they were latched
  task automatic start_xfer(input logic [7:0] tid, input logic [NC*SW-1:0] sel,
                            input logic [NC-1:0] en, input logic [CW-1:0] len);
    test_id = tid;
    for (int j = 0; j < int'(NP); j++) src_idx[j] = 0;
    src_on = '1;
    for (int i = 0; i < int'(NC); i++) begin
      exp_q[i].delete();
      if (en[i])
        for (int unsigned k = 0; k < 32'(len); k++)
          exp_q[i].push_back(mkword(int'(sel[i*SW +: SW]), k));
    end
    seen_vld    = '0;
    seen_rdy    = '0;
    cfg_sel_i   = sel;
    cfg_ch_en_i = en;
    cfg_len_i   = len;
    start_i     = 1'b1;
    step();
    start_i     = 1'b0;
    cfg_sel_i   = NC*SW'($urandom);
    cfg_ch_en_i = ~en;
    cfg_len_i   = '1;
    chk($sformatf("t%0d_busy_after_start", tid), 32'(busy_o), 32'd1);
  endtask

  // Wait for one done pulse with busy held; then confirm pulse width and drained scoreboard
  task automatic wait_done(input string tag, input int budget, output logic [31:0] perf);
    bit seen = 0;
    bit dropped = 0;
    perf = '0;
    for (int c = 0; c < budget; c++) begin
      if (done_o) begin
        seen = 1;
        perf = perf_stall_o;
        break;
      end
      if (!busy_o) dropped = 1;
      step();
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_held"}, 32'(dropped), 32'd0);
    step();
    chk({tag, "_done_single"}, 32'(done_o), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy_o), 32'd0);
    for (int i = 0; i < int'(NC); i++)
      chk($sformatf("%s_ch%0d_left", tag, i), 32'(exp_q[i].size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n_i = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    rst_n_i = 1'b1;
    step();

    // Identity map, len 8, DMA always ready
    dma_ready_i = '1;
    start_xfer(8'd1, {2'd3, 2'd2, 2'd1, 2'd0}, 4'hF, 16'd8);
    chk("t1_pea_ready_run", 32'(pea_dout_ready_o), 32'hF);
    step();
    chk("t1_valid_latency", 32'(dma_valid_o), 32'hF);
    wait_done("t1", 60, perf_val);

    // Fork of output 2 to all channels, len 4, channel 3 backpressured
    dma_ready_i = 4'b0111;
    start_xfer(8'd2, {2'd2, 2'd2, 2'd2, 2'd2}, 4'hF, 16'd4);
    repeat (8) step();
    chk("t2_ch3_valid", 32'(dma_valid_o[3]), 32'd1);
    chk("t2_busy", 32'(busy_o), 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk("t2_pea2_ready_low", 32'(pea_dout_ready_o[2]), 32'd0);
      step();
    end
    dma_ready_i = '1;
    wait_done("t2", 40, perf_val);

    // Fork with len above FIFO depth: full channel 3 must block the shared output
    dma_ready_i = 4'b0111;
    start_xfer(8'd3, {2'd2, 2'd2, 2'd2, 2'd2}, 4'hF, 16'd6);
    repeat (8) step();
    chk("t2b_busy", 32'(busy_o), 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk("t2b_pea2_ready_full", 32'(pea_dout_ready_o[2]), 32'd0);
      chk("t2b_ch3_valid", 32'(dma_valid_o[3]), 32'd1);
      step();
    end
    dma_ready_i = '1;
    wait_done("t2b", 40, perf_val);

    // Channels 0 and 2 only, len 3
    start_xfer(8'd4, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0101, 16'd3);
    wait_done("t3", 40, perf_val);
    chk("t3_disabled_valid", 32'(seen_vld & 4'b1010), 32'd0);
    chk("t3_unselected_ready", 32'(seen_rdy & 4'b1010), 32'd0);

    // Zero length: DRAIN then DONE two cycles after start, no pushes
    start_xfer(8'd5, {2'd3, 2'd2, 2'd1, 2'd0}, 4'hF, 16'd0);
    chk("t4_done_early", 32'(done_o), 32'd0);
    step();
    chk("t4_done_pulse", 32'(done_o), 32'd1);
    step();
    chk("t4_done_clear", 32'(done_o), 32'd0);
    chk("t4_idle", 32'(busy_o), 32'd0);
    chk("t4_no_ready", 32'(seen_rdy), 32'd0);
    chk("t4_no_valid", 32'(seen_vld), 32'd0);

    // Reset in the middle of RUN with FIFOs half full, then a clean len-2 transfer
    dma_ready_i = '0;
    start_xfer(8'd6, {2'd3, 2'd2, 2'd1, 2'd0}, 4'hF, 16'd8);
    step();
    step();
    chk("t5_half_full_valid", 32'(dma_valid_o), 32'hF);
    rst_n_i = 1'b0;
    #1;
    chk_idle_outputs("t5_abort");
    step();
    rst_n_i = 1'b1;
    dma_ready_i = '1;
    step();
    start_xfer(8'd7, {2'd3, 2'd2, 2'd1, 2'd0}, 4'hF, 16'd2);
    wait_done("t5", 40, perf_val);

    // Single channel held off for 5 cycles while valid
    dma_ready_i = 4'b1110;
    start_xfer(8'd8, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0001, 16'd1);
    for (int c = 0; c < 10; c++) if (!dma_valid_o[0]) step();
    chk("t6_valid_wait", 32'(dma_valid_o[0]), 32'd1);
    repeat (5) step();
    dma_ready_i = '1;
    wait_done("t6", 20, perf_val);
`ifdef MAGE_OUT_STREAM_PERF_EN
    chk("t6_perf_stall", perf_val, 32'd5);
`else
    chk("t6_perf_stall", perf_val, 32'd0);
`endif

    src_on = '0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
